wb_select_pipe: RTL and testbench
=================================

Name: wb_select_pipe

Overview:
- Parametrised write-back selector stage between the memory stage and the register file.
- Picks one of NSRC result sources per instruction and applies RISC-V load sign/zero extension and byte-lane alignment to the memory source.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is a registered signal.
- Also provides a bypass (forwarding) view of the head entry and a count of committed register writes.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8 and at least 32.
- NSRC, 4, number of result sources. Index 0 = ALU, 1 = memory (load formatting applied), 2 = PC+4, 3 = CSR/immediate.
- RA_W, 5, register address width.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept; registered.
- in_sel, input, $clog2(NSRC), source index.
- in_src, input, NSRC*XLEN, packed sources; source k occupies bits [k*XLEN +: XLEN].
- in_fmt, input, 3, load funct3.
- in_addr_lo, input, 2, load address bits [1:0].
- in_rd, input, RA_W, destination register.
- in_we, input, 1, instruction writes rd.
- out_ready, input, 1, register file / commit can accept.
- out_valid, output, 1, head entry valid.
- wr_en, output, 1, register write strobe.
- wr_addr, output, RA_W, register write address.
- wr_data, output, XLEN, register write data.
- byp_valid, output, 1, head entry will write a nonzero rd.
- byp_addr, output, RA_W, bypass address.
- byp_data, output, XLEN, bypass data.
- wr_count, output, CNT_W, number of committed writes.

Behaviour:
Reset:
- rst high at a clock edge clears both buffer entries and wr_count.
- After reset: out_valid=0, in_ready=1, wr_en=0, byp_valid=0, wr_count=0. wr_addr, wr_data, byp_addr and byp_data are 0.
- Reset mid-transfer discards all held entries. No write occurs in the reset cycle.

Format (combinational, before capture):
- Source is in_src[in_sel]. An out-of-range in_sel selects 0.
- Load formatting applies only when in_sel==1.
- Byte lane = in_addr_lo; halfword lane = in_addr_lo[1]; in_addr_lo[0] is ignored for halfwords.
- fmt 000 LB: sign-extend the selected byte.
- fmt 001 LH: sign-extend the selected halfword.
- fmt 010 LW: low 32 bits, sign-extended to XLEN.
- fmt 100 LBU: zero-extend the selected byte.
- fmt 101 LHU: zero-extend the selected halfword.
- Any other fmt: treated as LW.
- Stored we = in_we && (in_rd != 0).

Buffer:
- Two entries: head H and skid S.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Latency is 1 cycle: an entry accepted into an empty stage has out_valid=1 on the next cycle.
- Accept with H empty: data goes to H.
- Accept with H full and no pop: data goes to S.
- Accept with a pop and S empty: H is replaced with the new entry.
- Pop with S full: S moves to H; S is cleared.
- in_ready (registered) = !S.valid. Full = both entries valid → in_ready=0.
- Accept and pop in the same cycle keep throughput at 1 entry per cycle.
- Entry order is strictly preserved.

Outputs:
- out_valid = H.valid.
- wr_en = out_valid && out_ready && H.we (combinational from registers and out_ready).
- wr_addr = H.rd and wr_data = H.data whenever H is valid; both are 0 otherwise.
- byp_valid = H.valid && H.we. byp_addr = H.rd. byp_data = H.data, independent of out_ready.

Counter:
- wr_count increments by 1 on every cycle with wr_en=1.
- It wraps modulo 2^CNT_W.

Decomposition:
- Package wb_pkg holds:
  - source index constants SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_CSR=3;
  - funct3 constants F_LB, F_LH, F_LW, F_LBU, F_LHU;
  - an entry struct {valid, we, rd, data}.
- One sub-module is natural: load_fmt. It is purely combinational: (word, fmt, addr_lo) → extended data.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, wr_count=0, wr_en=0.
2. Load format: src1=0x80FF7F01, sel=1.
   - LB addr_lo=3 → 0xFFFFFF80.
   - LBU addr_lo=1 → 0x0000007F.
   - LH addr_lo=2 → 0xFFFF80FF.
   - LHU addr_lo=3 → 0x000080FF.
   - fmt=011 → 0x80FF7F01.
   Each appears one cycle after accept.
3. x0 suppression: sel=0, src0=0x12345678, rd=0, we=1 → out_valid=1, wr_en=0, byp_valid=0, wr_count unchanged.
4. Backpressure: out_ready=0, send A (rd 5) then B (rd 6).
   - in_ready=0 after B is accepted; C is held upstream.
   - Raise out_ready → writes A, B, C in order on consecutive cycles; wr_count=3.
5. Streaming: out_ready=1, in_valid=1 for 8 cycles → 8 consecutive wr_en pulses, in_ready never drops, each write 1 cycle after its accept.
6. Reset mid-operation: with the buffer full, assert rst=1 → next cycle out_valid=0, in_ready=1, wr_count=0, and no wr_en pulse for the discarded entries.

Source files
------------

// File: rtl/wb_select_pipe_pkg.sv
// Shared constants for the write-back selector: source indices, load funct3
// codes and the buffer entry layout for the default 32-bit configuration.
package wb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_CSR = 3;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  localparam int WB_XLEN = 32;
  localparam int WB_RA_W = 5;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [WB_RA_W-1:0] rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_select_pipe_load_fmt.sv
// RISC-V load data formatting: lane selection plus sign/zero extension.
// Purely combinational; unknown funct3 codes fall back to LW.
module load_fmt
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      fmt,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] low_word;

  // Halfword lanes only look at addr_lo[1]; a misaligned low bit is ignored.
  assign byte_lane = word[{addr_lo, 3'b000} +: 8];
  assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];
  assign low_word  = word[31:0];

  always_comb begin
    data = XLEN'($signed(low_word));
    case (fmt)
      F_LB:    data = XLEN'($signed(byte_lane));
      F_LH:    data = XLEN'($signed(half_lane));
      F_LW:    data = XLEN'($signed(low_word));
      F_LBU:   data = XLEN'(byte_lane);
      F_LHU:   data = XLEN'(half_lane);
      default: data = XLEN'($signed(low_word));
    endcase
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back selector stage: picks a result source, formats loads, and holds
// results in a head/skid buffer so the upstream ready is a flop output.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NSRC)-1:0]      in_sel,
  input  logic [NSRC*XLEN-1:0]         in_src,
  input  logic [2:0]                   in_fmt,
  input  logic [1:0]                   in_addr_lo,
  input  logic [RA_W-1:0]              in_rd,
  input  logic                         in_we,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic                         wr_en,
  output logic [RA_W-1:0]              wr_addr,
  output logic [XLEN-1:0]              wr_data,
  output logic                         byp_valid,
  output logic [RA_W-1:0]              byp_addr,
  output logic [XLEN-1:0]              byp_data,
  output logic [CNT_W-1:0]             wr_count
);

  localparam int SEL_W = $clog2(NSRC);

  generate
    if ((XLEN % 8) != 0 || XLEN < 32) begin : g_bad_xlen
      $error("wb_select_pipe: XLEN must be a multiple of 8 and at least 32");
    end
    if (NSRC < 2) begin : g_bad_nsrc
      $error("wb_select_pipe: NSRC must include the memory source");
    end
  endgenerate

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid may not depend on ready, and in_ready is a flop output.
  logic            accept;
  logic            pop;
  logic            in_ready_q;
  entry_t          head_q, head_n;
  entry_t          skid_q, skid_n;
  entry_t          new_entry;
  logic [XLEN-1:0] src_word;
  logic [XLEN-1:0] mem_word;
  logic [XLEN-1:0] sel_data;
  logic [CNT_W-1:0] count_q;

  // Out-of-range selects fall through the loop and leave zero.
  always_comb begin
    src_word = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SEL_W'(k)) src_word = in_src[k*XLEN +: XLEN];
    end
  end

  load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .word    (src_word),
    .fmt     (in_fmt),
    .addr_lo (in_addr_lo),
    .data    (mem_word)
  );

  assign sel_data = (in_sel == SEL_W'(SRC_MEM)) ? mem_word : src_word;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.we    = in_we && (in_rd != '0);
    new_entry.rd    = in_rd;
    new_entry.data  = sel_data;
  end

  assign accept = in_valid && in_ready_q;
  assign pop    = head_q.valid && out_ready;

  // Pop first, then place the new entry in the first free slot; this keeps
  // order and lets accept+pop sustain one entry per cycle.
  always_comb begin
    head_n = head_q;
    skid_n = skid_q;
    if (pop) begin
      if (skid_q.valid) begin
        head_n = skid_q;
        skid_n = '0;
      end else begin
        head_n = '0;
      end
    end
    if (accept) begin
      if (!head_n.valid) head_n = new_entry;
      else               skid_n = new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      count_q    <= '0;
    end else begin
      head_q     <= head_n;
      skid_q     <= skid_n;
      in_ready_q <= !skid_n.valid;
      if (wr_en) count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = head_q.valid;
  // Held entries are being discarded during reset, so no write may escape.
  assign wr_en     = head_q.valid && out_ready && head_q.we && !rst;
  assign wr_addr   = head_q.valid ? head_q.rd   : '0;
  assign wr_data   = head_q.valid ? head_q.data : '0;
  assign byp_valid = head_q.valid && head_q.we;
  assign byp_addr  = head_q.rd;
  assign byp_data  = head_q.data;
  assign wr_count  = count_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: load formatting, x0 suppression,
// backpressure ordering, streaming throughput and reset mid-transfer.
module tb_wb_select_pipe;
  import wb_pkg::*;

  localparam int XLEN  = 32;
  localparam int NSRC  = 4;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_sel;
  logic [NSRC*XLEN-1:0]    in_src;
  logic [2:0]              in_fmt;
  logic [1:0]              in_addr_lo;
  logic [RA_W-1:0]         in_rd;
  logic                    in_we;
  logic                    out_ready;
  logic                    out_valid;
  logic                    wr_en;
  logic [RA_W-1:0]         wr_addr;
  logic [XLEN-1:0]         wr_data;
  logic                    byp_valid;
  logic [RA_W-1:0]         byp_addr;
  logic [XLEN-1:0]         byp_data;
  logic [CNT_W-1:0]        wr_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  wb_select_pipe #(.XLEN(XLEN), .NSRC(NSRC), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_src     (in_src),
    .in_fmt     (in_fmt),
    .in_addr_lo (in_addr_lo),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data),
    .wr_count   (wr_count)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] word, input logic [2:0] fmt,
                       input logic [1:0] lo, input logic [RA_W-1:0] rd, input logic we);
    in_valid   = 1'b1;
    in_sel     = sel;
    in_src     = '0;
    in_src[int'(sel)*XLEN +: XLEN] = word;
    in_fmt     = fmt;
    in_addr_lo = lo;
    in_rd      = rd;
    in_we      = we;
  endtask

  logic [2:0]  vec_fmt [6];
  logic [1:0]  vec_lo  [6];
  logic [31:0] vec_exp [6];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_src = '0; in_fmt = '0;
    in_addr_lo = '0; in_rd = '0; in_we = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_wr_count",  64'(wr_count),  64'd0);
    chk("rst_wr_en",     64'(wr_en),     64'd0);
    chk("rst_byp_valid", 64'(byp_valid), 64'd0);
    chk("rst_wr_data",   64'(wr_data),   64'd0);
    chk("rst_byp_addr",  64'(byp_addr),  64'd0);

    // Load formatting on src1 = 0x80FF7F01
    vec_fmt[0] = F_LB;   vec_lo[0] = 2'd3; vec_exp[0] = 32'hFFFFFF80;
    vec_fmt[1] = F_LBU;  vec_lo[1] = 2'd1; vec_exp[1] = 32'h0000007F;
    vec_fmt[2] = F_LH;   vec_lo[2] = 2'd2; vec_exp[2] = 32'hFFFF80FF;
    vec_fmt[3] = F_LHU;  vec_lo[3] = 2'd3; vec_exp[3] = 32'h000080FF;
    vec_fmt[4] = 3'b011; vec_lo[4] = 2'd0; vec_exp[4] = 32'h80FF7F01;
    vec_fmt[5] = F_LB;   vec_lo[5] = 2'd0; vec_exp[5] = 32'h00000001;
    for (int i = 0; i < 6; i++) begin
      drive(2'd1, 32'h80FF7F01, vec_fmt[i], vec_lo[i], RA_W'(i + 1), 1'b1);
      tick();
      chk($sformatf("fmt%0d_data", i), 64'(wr_data), 64'(vec_exp[i]));
      chk($sformatf("fmt%0d_wr_en", i), 64'(wr_en), 64'd1);
      chk($sformatf("fmt%0d_addr", i), 64'(wr_addr), 64'(i + 1));
      exp_cnt++;
    end
    // Non-memory source with an LB funct3 must pass through unformatted.
    drive(2'd0, 32'hDEADBEEF, F_LB, 2'd3, 5'd9, 1'b1);
    tick();
    chk("alu_no_fmt", 64'(wr_data), 64'hDEADBEEF);
    exp_cnt++;
    in_valid = 1'b0;
    tick();
    chk("fmt_drain_valid", 64'(out_valid), 64'd0);
    chk("fmt_count", 64'(wr_count), 64'(exp_cnt));

    // x0 suppression
    drive(2'd0, 32'h12345678, F_LW, 2'd0, 5'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("x0_out_valid", 64'(out_valid), 64'd1);
    chk("x0_wr_en",     64'(wr_en),     64'd0);
    chk("x0_byp_valid", 64'(byp_valid), 64'd0);
    chk("x0_wr_data",   64'(wr_data),   64'h12345678);
    tick();
    chk("x0_count", 64'(wr_count), 64'(exp_cnt));

    // Backpressure: A and B fill the buffer, C waits upstream
    out_ready = 1'b0;
    drive(2'd0, 32'hAAAA0005, F_LW, 2'd0, 5'd5, 1'b1);
    tick();
    chk("bp_ready_after_a", 64'(in_ready), 64'd1);
    drive(2'd0, 32'hBBBB0006, F_LW, 2'd0, 5'd6, 1'b1);
    tick();
    chk("bp_ready_after_b", 64'(in_ready), 64'd0);
    chk("bp_wr_en_held",    64'(wr_en),    64'd0);
    chk("bp_byp_addr",      64'(byp_addr), 64'd5);
    chk("bp_byp_data",      64'(byp_data), 64'hAAAA0005);
    drive(2'd0, 32'hCCCC0007, F_LW, 2'd0, 5'd7, 1'b1);
    tick();
    chk("bp_c_blocked", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_a_wr_en", 64'(wr_en),   64'd1);
    chk("bp_a_addr",  64'(wr_addr), 64'd5);
    chk("bp_a_data",  64'(wr_data), 64'hAAAA0005);
    tick();
    chk("bp_b_wr_en", 64'(wr_en),   64'd1);
    chk("bp_b_addr",  64'(wr_addr), 64'd6);
    chk("bp_b_data",  64'(wr_data), 64'hBBBB0006);
    tick();
    in_valid = 1'b0;
    chk("bp_c_wr_en", 64'(wr_en),   64'd1);
    chk("bp_c_addr",  64'(wr_addr), 64'd7);
    chk("bp_c_data",  64'(wr_data), 64'hCCCC0007);
    tick();
    exp_cnt += 3;
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_count",   64'(wr_count),  64'(exp_cnt));

    // Streaming: one write per cycle, one cycle after each accept
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 32'h00000100 + 32'(i), F_LW, 2'd0, RA_W'(i + 10), 1'b1);
      tick();
      chk($sformatf("st%0d_wr_en", i), 64'(wr_en), 64'd1);
      chk($sformatf("st%0d_data", i), 64'(wr_data), 64'(32'h00000100 + 32'(i)));
      chk($sformatf("st%0d_ready", i), 64'(in_ready), 64'd1);
      exp_cnt++;
    end
    in_valid = 1'b0;
    tick();
    chk("st_drained", 64'(out_valid), 64'd0);
    chk("st_count",   64'(wr_count),  64'(exp_cnt));

    // Reset with the buffer full
    out_ready = 1'b0;
    drive(2'd3, 32'h0000D001, F_LW, 2'd0, 5'd3, 1'b1);
    tick();
    drive(2'd3, 32'h0000D002, F_LW, 2'd0, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mr_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr_no_write_in_rst", 64'(wr_en), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_in_ready",  64'(in_ready),  64'd1);
    chk("mr_wr_count",  64'(wr_count),  64'd0);
    chk("mr_wr_en",     64'(wr_en),     64'd0);
    tick();
    chk("mr_still_empty", 64'(out_valid), 64'd0);
    chk("mr_count_hold",  64'(wr_count),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
